knn_sdram_emu: RTL and testbench



---
 rtl/knn_pkg.sv | 13 +
 rtl/knn_sdram_emu_if.sv | 29 ++
 rtl/knn_rr_arbiter.sv | 29 ++
 rtl/knn_sdram_emu.sv | 150 +++++++++++++++
 tb/tb_knn_sdram_emu.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/knn_pkg.sv
// Shared types and default geometry for the KNN SDRAM emulator and its benches.
package knn_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_t;

  localparam int KNN_W      = 16;
  localparam int KNN_ADDR_W = 10;

endpackage

// File: rtl/knn_sdram_emu_if.sv
// Multi-channel Avalon-style requester bus plus emulator status outputs.
interface knn_sdram_emu_if
  import knn_pkg::*;
#(
  parameter int CH     = 2,
  parameter int W      = KNN_W,
  parameter int ADDR_W = KNN_ADDR_W
);
  logic [CH-1:0]        ch_read;
  logic [CH-1:0]        ch_write;
  logic [CH*ADDR_W-1:0] ch_addr;
  logic [CH*W-1:0]      ch_writedata;
  logic [CH-1:0]        ch_waitrequest;
  logic [CH*W-1:0]      ch_readdata;
  logic [CH-1:0]        ch_readdatavalid;
  logic                 busy;
  logic                 err;
  logic [31:0]          txn_count;

  modport master (
    output ch_read, ch_write, ch_addr, ch_writedata,
    input  ch_waitrequest, ch_readdata, ch_readdatavalid, busy, err, txn_count
  );

  modport slave (
    input  ch_read, ch_write, ch_addr, ch_writedata,
    output ch_waitrequest, ch_readdata, ch_readdatavalid, busy, err, txn_count
  );
endinterface

// File: rtl/knn_rr_arbiter.sv
// Combinational round-robin arbiter: first requester after the pointer wins.
module knn_rr_arbiter #(
  parameter  int CH    = 2,
  localparam int IDX_W = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic [CH-1:0]    i_req,
  input  logic [IDX_W-1:0] i_pointer,
  input  logic             i_enable,
  output logic [IDX_W-1:0] o_grant,
  output logic             o_grant_valid
);

  int idx;

  // Scan from farthest to nearest so the nearest requester after the pointer overrides.
  always_comb begin
    o_grant       = '0;
    o_grant_valid = 1'b0;
    idx           = 0;
    for (int k = CH; k >= 1; k--) begin
      idx = (int'(i_pointer) + k) % CH;
      if (i_enable && i_req[idx]) begin
        o_grant       = IDX_W'(idx);
        o_grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/knn_sdram_emu.sv
// Word-addressed SDRAM emulator: CH requesters, round-robin arbitration,
// one transaction in flight, configurable read and write latencies.
module knn_sdram_emu
  import knn_pkg::*;
#(
  parameter int CH     = 2,
  parameter int W      = KNN_W,
  parameter int ADDR_W = KNN_ADDR_W,
  parameter int RD_LAT = 3,
  parameter int WR_LAT = 9
) (
  input logic              clk,
  input logic              rst,
  knn_sdram_emu_if.slave   s_bus
);

  localparam int IDX_W = (CH > 1) ? $clog2(CH) : 1;
  localparam int DEPTH = 1 << ADDR_W;

  state_t              r_state;
  state_t              w_state_next;
  logic [IDX_W-1:0]    r_ptr;
  logic [IDX_W-1:0]    r_ch;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_cnt;
  logic [31:0]         r_txn;
  logic                r_err;
  logic [CH-1:0]       r_rdv;
  logic [CH*W-1:0]     r_rdata;
  logic [W-1:0]        r_mem [DEPTH];

  logic [CH-1:0]       w_req;
  logic [IDX_W-1:0]    w_grant;
  logic                w_gvalid;
  logic                w_acc;
  logic                w_acc_rd;
  logic                w_acc_wr;
  logic [ADDR_W-1:0]   w_acc_addr;
  logic [W-1:0]        w_acc_wdata;
  logic                w_cap;
  logic [IDX_W-1:0]    w_cap_ch;
  logic [ADDR_W-1:0]   w_cap_addr;

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      assign w_req[gi] = s_bus.ch_read[gi] | s_bus.ch_write[gi];
      assign s_bus.ch_waitrequest[gi] = !(w_gvalid && (w_grant == IDX_W'(gi)));
    end
  endgenerate

  // Gating with rst keeps every waitrequest high while reset is asserted.
  knn_rr_arbiter #(.CH(CH)) u_arb (
    .i_req         (w_req),
    .i_pointer     (r_ptr),
    .i_enable      ((r_state == IDLE) && !rst),
    .o_grant       (w_grant),
    .o_grant_valid (w_gvalid)
  );

  assign w_acc = w_gvalid;

  always_comb begin
    w_acc_rd    = 1'b0;
    w_acc_wr    = 1'b0;
    w_acc_addr  = '0;
    w_acc_wdata = '0;
    for (int i = 0; i < CH; i++) begin
      if (w_grant == IDX_W'(i)) begin
        w_acc_rd    = s_bus.ch_read[i];
        w_acc_wr    = s_bus.ch_write[i];
        w_acc_addr  = s_bus.ch_addr[i*ADDR_W +: ADDR_W];
        w_acc_wdata = s_bus.ch_writedata[i*W +: W];
      end
    end
  end

  // Read data is fetched one cycle before the valid pulse; with RD_LAT=1 that is the acceptance edge.
  assign w_cap      = (RD_LAT == 1) ? (w_acc && !w_acc_wr)
                                    : ((r_state == RD_WAIT) && (r_cnt == 32'd1));
  assign w_cap_ch   = (RD_LAT == 1) ? w_grant    : r_ch;
  assign w_cap_addr = (RD_LAT == 1) ? w_acc_addr : r_addr;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_acc) begin
          if (w_acc_wr) w_state_next = (WR_LAT > 1) ? WR_WAIT : IDLE;
          else          w_state_next = RD_WAIT;
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (r_cnt == 32'd0) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= IDX_W'(CH - 1);
      r_ch    <= '0;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_txn   <= '0;
      r_err   <= 1'b0;
      r_rdv   <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_next;
      r_rdv   <= '0;
      if (w_acc) begin
        r_ptr  <= w_grant;
        r_ch   <= w_grant;
        r_addr <= w_acc_addr;
        if (r_txn != '1) r_txn <= r_txn + 32'd1;
        if (w_acc_wr) begin
          if (w_acc_rd) r_err <= 1'b1;
          r_cnt <= (WR_LAT > 1) ? 32'(WR_LAT - 2) : 32'd0;
        end else begin
          r_cnt <= 32'(RD_LAT - 1);
        end
      end else if ((r_state != IDLE) && (r_cnt != 32'd0)) begin
        r_cnt <= r_cnt - 32'd1;
      end
      if (w_cap) begin
        for (int i = 0; i < CH; i++) begin
          if (w_cap_ch == IDX_W'(i)) begin
            r_rdata[i*W +: W] <= r_mem[w_cap_addr];
            r_rdv[i]          <= 1'b1;
          end
        end
      end
    end
  end

  // Storage is not reset; a write commits at its acceptance edge.
  always_ff @(posedge clk) begin
    if (w_acc && w_acc_wr) r_mem[w_acc_addr] <= w_acc_wdata;
  end

  assign s_bus.ch_readdata      = r_rdata;
  assign s_bus.ch_readdatavalid = r_rdv;
  assign s_bus.busy             = (r_state != IDLE);
  assign s_bus.err              = r_err;
  assign s_bus.txn_count        = r_txn;

endmodule

// File: tb/tb_knn_sdram_emu.sv
// Scoreboard bench: default emulator (CH=2, RD_LAT=3, WR_LAT=9) and a CH=1, RD_LAT=1, WR_LAT=1 instance.
module tb_knn_sdram_emu;

  typedef struct {
    int          ch;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;
  int   exp_txn_a;
  exp_t qa[$];
  exp_t qb[$];

  knn_sdram_emu_if #(.CH(2), .W(16), .ADDR_W(10)) ifa ();
  knn_sdram_emu_if #(.CH(1), .W(16), .ADDR_W(10)) ifb ();

  knn_sdram_emu #(.CH(2), .W(16), .ADDR_W(10), .RD_LAT(3), .WR_LAT(9)) u_dut_a (
    .clk   (clk),
    .rst   (rst),
    .s_bus (ifa)
  );

  knn_sdram_emu #(.CH(1), .W(16), .ADDR_W(10), .RD_LAT(1), .WR_LAT(1)) u_dut_b (
    .clk   (clk),
    .rst   (rst),
    .s_bus (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end else begin
      $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
    end
  endfunction

  function automatic exp_t mk(input int ch, input logic [15:0] data, input int c);
    exp_t e;
    e.ch   = ch;
    e.data = data;
    e.cyc  = c;
    return e;
  endfunction

  // Monitor: every readdatavalid pulse must match the oldest expectation.
  always @(negedge clk) begin
    for (int ch = 0; ch < 2; ch++) begin
      if (ifa.ch_readdatavalid[ch] === 1'b1) begin
        if (qa.size() == 0) begin
          chk("a_unexpected_valid", 64'(ch), 64'hFFFF);
        end else begin
          exp_t e;
          e = qa.pop_front();
          chk("a_rd_channel", 64'(ch), 64'(e.ch));
          chk("a_rd_data", 64'(ifa.ch_readdata[ch*16 +: 16]), 64'(e.data));
          chk("a_rd_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
    end
    if (ifb.ch_readdatavalid[0] === 1'b1) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_valid", 64'd0, 64'hFFFF);
      end else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_rd_data", 64'(ifb.ch_readdata), 64'(e.data));
        chk("b_rd_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Issue one request on DUT A and hold it until accepted; returns the acceptance cycle.
  task automatic txn_a(input int ch, input bit rd, input bit wr, input logic [9:0] addr,
                       input logic [15:0] data, output int acc);
    int budget;
    bit done;
    budget = 0;
    done   = 1'b0;
    acc    = -1;
    ifa.ch_read[ch]             = rd;
    ifa.ch_write[ch]            = wr;
    ifa.ch_addr[ch*10 +: 10]    = addr;
    ifa.ch_writedata[ch*16 +: 16] = data;
    while (!done) begin
      @(negedge clk);
      if (ifa.ch_waitrequest[ch] == 1'b0) begin
        done = 1'b1;
        acc  = cyc;
        exp_txn_a++;
      end else if (++budget > 50) begin
        chk("accept_timeout", 64'd0, 64'd1);
        done = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    ifa.ch_read[ch]  = 1'b0;
    ifa.ch_write[ch] = 1'b0;
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    do begin
      @(negedge clk);
      b++;
    end while ((ifa.busy !== 1'b0 || qa.size() != 0 || qb.size() != 0) && b < 300);
    if (b >= 300) chk("idle_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w_acc;
    int r_acc;
    int acc;
    int order[3];
    int accc[3];
    int k;
    int budget;

    n_checks  = 0;
    n_fail    = 0;
    exp_txn_a = 0;
    ifa.ch_read = '0; ifa.ch_write = '0; ifa.ch_addr = '0; ifa.ch_writedata = '0;
    ifb.ch_read = '0; ifb.ch_write = '0; ifb.ch_addr = '0; ifb.ch_writedata = '0;

    // Reset with requests asserted: nothing may be accepted.
    rst = 1'b1;
    ifa.ch_read = 2'b11;
    ifb.ch_read = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_wreq_a", 64'(ifa.ch_waitrequest), 64'h3);
    chk("rst_wreq_b", 64'(ifb.ch_waitrequest), 64'h1);
    chk("rst_busy", 64'(ifa.busy), 64'd0);
    chk("rst_err", 64'(ifa.err), 64'd0);
    chk("rst_txn", 64'(ifa.txn_count), 64'd0);
    chk("rst_rdv", 64'(ifa.ch_readdatavalid), 64'd0);
    chk("rst_rdata", 64'(ifa.ch_readdata), 64'd0);
    @(posedge clk);
    #1;
    ifa.ch_read = '0;
    ifb.ch_read = '0;
    rst = 1'b0;

    // DUT B: write then read on consecutive cycles.
    @(posedge clk);
    #1;
    ifb.ch_write = 1'b1; ifb.ch_addr = 10'd3; ifb.ch_writedata = 16'hA5A5;
    @(negedge clk);
    chk("b_wr_accept", 64'(ifb.ch_waitrequest), 64'd0);
    @(posedge clk);
    #1;
    ifb.ch_write = 1'b0; ifb.ch_read = 1'b1;
    @(negedge clk);
    chk("b_rd_accept", 64'(ifb.ch_waitrequest), 64'd0);
    qb.push_back(mk(0, 16'hA5A5, cyc + 1));
    @(posedge clk);
    #1;
    ifb.ch_read = 1'b0;
    chk("b_txn", 64'(ifb.txn_count), 64'd2);

    // Write then read back on ch0.
    txn_a(0, 1'b0, 1'b1, 10'd5, 16'hBEEF, w_acc);
    chk("wr_busy", 64'(ifa.busy), 64'd1);
    txn_a(0, 1'b1, 1'b0, 10'd5, 16'h0000, r_acc);
    qa.push_back(mk(0, 16'hBEEF, r_acc + 3));
    chk("wr_to_rd_gap", 64'(r_acc - w_acc), 64'd9);
    chk("txn_after_two", 64'(ifa.txn_count), 64'(exp_txn_a));
    wait_idle();

    // Preload, then two channels reading continuously.
    txn_a(0, 1'b0, 1'b1, 10'd1, 16'h1111, acc);
    txn_a(1, 1'b0, 1'b1, 10'd2, 16'h2222, acc);
    wait_idle();
    ifa.ch_addr = {10'd2, 10'd1};
    ifa.ch_read = 2'b11;
    k = 0;
    budget = 0;
    while (k < 3 && budget < 100) begin
      @(negedge clk);
      budget++;
      for (int ch = 0; ch < 2; ch++) begin
        if (ifa.ch_waitrequest[ch] == 1'b0 && k < 3) begin
          order[k] = ch;
          accc[k]  = cyc;
          exp_txn_a++;
          qa.push_back(mk(ch, (ch == 0) ? 16'h1111 : 16'h2222, cyc + 3));
          k++;
        end
      end
    end
    @(posedge clk);
    #1;
    ifa.ch_read = '0;
    chk("arb_grants", 64'(k), 64'd3);
    chk("arb_order0", 64'(order[0]), 64'd0);
    chk("arb_order1", 64'(order[1]), 64'd1);
    chk("arb_order2", 64'(order[2]), 64'd0);
    chk("arb_gap01", 64'(accc[1] - accc[0]), 64'd4);
    chk("arb_gap12", 64'(accc[2] - accc[1]), 64'd4);
    wait_idle();
    chk("arb_txn", 64'(ifa.txn_count), 64'(exp_txn_a));

    // Read and write together on ch1: performed as a write, err sticky.
    txn_a(1, 1'b1, 1'b1, 10'd7, 16'h0042, acc);
    wait_idle();
    chk("err_set", 64'(ifa.err), 64'd1);
    txn_a(0, 1'b1, 1'b0, 10'd7, 16'h0000, r_acc);
    qa.push_back(mk(0, 16'h0042, r_acc + 3));
    wait_idle();
    chk("err_sticky", 64'(ifa.err), 64'd1);

    // Reset asserted in cycle 2 of a read.
    txn_a(0, 1'b1, 1'b0, 10'd5, 16'h0000, r_acc);
    @(posedge clk);
    #1;
    rst = 1'b1;
    ifa.ch_read = 2'b11;
    @(negedge clk);
    chk("midrd_wreq_in_rst", 64'(ifa.ch_waitrequest), 64'h3);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("midrd_busy_in_rst", 64'(ifa.busy), 64'd0);
    chk("midrd_wreq_in_rst2", 64'(ifa.ch_waitrequest), 64'h3);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_txn_a = 0;
    ifa.ch_read = 2'b01;
    ifa.ch_addr[9:0] = 10'd5;
    @(negedge clk);
    chk("accept_after_rst", 64'(ifa.ch_waitrequest[0]), 64'd0);
    exp_txn_a++;
    qa.push_back(mk(0, 16'hBEEF, cyc + 3));
    @(posedge clk);
    #1;
    ifa.ch_read = '0;
    chk("txn_after_rst", 64'(ifa.txn_count), 64'(exp_txn_a));
    chk("err_after_rst", 64'(ifa.err), 64'd0);
    wait_idle();

    // Request dropped while a write is busy: no side effects.
    txn_a(1, 1'b0, 1'b1, 10'd9, 16'h5555, acc);
    ifa.ch_write[0] = 1'b1;
    ifa.ch_addr[9:0] = 10'd5;
    ifa.ch_writedata[15:0] = 16'hDEAD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("drop_wreq_high", 64'(ifa.ch_waitrequest[0]), 64'd1);
    end
    @(posedge clk);
    #1;
    ifa.ch_write[0] = 1'b0;
    wait_idle();
    chk("drop_txn", 64'(ifa.txn_count), 64'(exp_txn_a));
    txn_a(0, 1'b1, 1'b0, 10'd5, 16'h0000, r_acc);
    qa.push_back(mk(0, 16'hBEEF, r_acc + 3));
    wait_idle();
    chk("final_txn", 64'(ifa.txn_count), 64'(exp_txn_a));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
